// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encodings, opcodes and ALU/PC select constants for multicycle_control
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/pc_enable_logic.sv
// pc_enable_logic: PC load enable from unconditional (FETCH/JUMP) and branch-qualified terms.
// BNE_SUPPORT_EN adds the BNE (taken on ~zero) term.
module pc_enable_logic
  import mips_ctrl_pkg::*;
(
  input  logic       uncond,
  input  logic       branch,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en
);
  logic take;
`ifdef BNE_SUPPORT_EN
  assign take = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
`else
  assign take = opcode == OP_BEQ && zero;
`endif
  assign pc_en = uncond || (branch && take);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS control FSM with retired-instruction counter.
// BNE_SUPPORT_EN enables decoding of opcode 000101 as BNE.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCEn,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  State,
  output logic [31:0] InstrCount
);
  state_t state, next;
  logic [31:0] count;
  logic iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, pc_en, retire;
  logic [1:0] alu_src_b, alu_op, pc_source;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      count <= '0;
    end else begin
      state <= next;
      if (retire) count <= count + 32'd1;
    end
  always_comb begin
    next       = FETCH;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    pc_source  = PC_ALU;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        next      = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (Opcode)
          OP_RTYPE:      next = EXEC;
          OP_LW, OP_SW:  next = MEMADR;
          OP_BEQ:        next = BRANCH;
`ifdef BNE_SUPPORT_EN
          OP_BNE:        next = BRANCH;
`endif
          OP_ADDI:       next = ADDIEX;
          OP_J:          next = JUMP;
          default:       next = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next      = Opcode == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        next     = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        next      = MemReady ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        next      = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PC_ALUOUT;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        next      = ADDIWB;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP:   pc_source = PC_JUMP;
      default: next = FETCH;
    endcase
  end
  assign retire = state == MEMWB || state == ALUWB || state == BRANCH || state == ADDIWB ||
                  state == JUMP || (state == MEMWR && MemReady);
  pc_enable_logic u_pc_en (
    .uncond (state == JUMP || (state == FETCH && MemReady)),
    .branch (state == BRANCH),
    .opcode (Opcode),
    .zero   (Zero),
    .pc_en  (pc_en)
  );
  // Reset masks the decoded controls so FETCH's strobes stay low while reset is held.
  assign PCEn       = reset && pc_en;
  assign IorD       = reset && iord;
  assign MemRead    = reset && mem_read;
  assign MemWrite   = reset && mem_write;
  assign IRWrite    = reset && state == FETCH && MemReady;
  assign RegWrite   = reset && reg_write;
  assign RegDst     = reset && reg_dst;
  assign MemtoReg   = reset && mem_to_reg;
  assign ALUSrcA    = reset && alu_src_a;
  assign ALUSrcB    = {2{reset}} & alu_src_b;
  assign ALUOp      = {2{reset}} & alu_op;
  assign PCSource   = {2{reset}} & pc_source;
  assign State      = state;
  assign InstrCount = count;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven, scoreboarded check of multicycle_control (BNE rows follow BNE_SUPPORT_EN).
module tb_multicycle_control;
  logic clk = 1'b0, reset = 1'b0, Zero = 1'b0, MemReady = 1'b0;
  logic [5:0] Opcode = '0;
  logic PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  logic [31:0] InstrCount;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .State(State), .InstrCount(InstrCount)
  );
  // ctl = {PCEn,IorD,MemRead,MemWrite,IRWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  localparam logic [14:0] C_ZERO = 15'b0;
  localparam logic [14:0] F_RDY  = 15'b1_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [14:0] F_WAIT = 15'b0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [14:0] DEC    = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [14:0] MADR   = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [14:0] MRD    = 15'b0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [14:0] MWB    = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [14:0] MWR    = 15'b0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [14:0] EXE    = 15'b0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [14:0] AWB    = 15'b0_0_0_0_0_1_1_0_0_00_00_00;
  localparam logic [14:0] BR_T   = 15'b1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] BR_N   = 15'b0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [14:0] AIEX   = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [14:0] AIWB   = 15'b0_0_0_0_0_1_0_0_0_00_00_00;
  localparam logic [14:0] JMP    = 15'b1_0_0_0_0_0_0_0_0_00_00_10;
  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [31:0] cnt;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  function automatic logic [14:0] ctl_now();
    return {PCEn, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
            ALUSrcB, ALUOp, PCSource};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic [5:0] op, input logic z, input logic mr, input logic [3:0] st,
                     input logic [14:0] ctl, input logic [31:0] cnt);
    vec_t v;
    v.op = op; v.z = z; v.mr = mr; v.st = st; v.ctl = ctl; v.cnt = cnt;
    vecs.push_back(v);
  endtask
  task automatic drive(input vec_t v, input string tag);
    vec_t e;
    Opcode = v.op; Zero = v.z; MemReady = v.mr;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    check({tag, ".state"}, {28'd0, State}, {28'd0, e.st});
    check({tag, ".ctl"}, {17'd0, ctl_now()}, {17'd0, e.ctl});
    check({tag, ".count"}, InstrCount, e.cnt);
    @(negedge clk);
  endtask
  task automatic run(input logic [5:0] op, input logic z, input logic mr, input logic [3:0] st,
                     input logic [14:0] ctl, input logic [31:0] cnt, input string tag);
    vec_t v;
    v.op = op; v.z = z; v.mr = mr; v.st = st; v.ctl = ctl; v.cnt = cnt;
    drive(v, tag);
  endtask
  initial begin
    add(6'b000000, 0, 1, 0, F_RDY, 0); add(6'b000000, 0, 1, 1, DEC, 0);
    add(6'b000000, 0, 1, 6, EXE, 0);   add(6'b000000, 0, 1, 7, AWB, 0);
    add(6'b100011, 0, 1, 0, F_RDY, 1); add(6'b100011, 0, 1, 1, DEC, 1);
    add(6'b100011, 0, 1, 2, MADR, 1);
    for (int i = 0; i < 3; i++) add(6'b100011, 0, 0, 3, MRD, 1);
    add(6'b100011, 0, 1, 3, MRD, 1);   add(6'b100011, 0, 1, 4, MWB, 1);
    add(6'b000100, 1, 0, 0, F_WAIT, 2);
    add(6'b000100, 1, 1, 0, F_RDY, 2); add(6'b000100, 1, 1, 1, DEC, 2);
    add(6'b000100, 1, 1, 8, BR_T, 2);
    add(6'b000100, 0, 1, 0, F_RDY, 3); add(6'b000100, 0, 1, 1, DEC, 3);
    add(6'b000100, 0, 1, 8, BR_N, 3);
    add(6'b101011, 0, 1, 0, F_RDY, 4); add(6'b101011, 0, 1, 1, DEC, 4);
    add(6'b101011, 0, 1, 2, MADR, 4);  add(6'b101011, 0, 0, 5, MWR, 4);
    add(6'b101011, 0, 1, 5, MWR, 4);
    add(6'b001000, 0, 1, 0, F_RDY, 5); add(6'b001000, 0, 1, 1, DEC, 5);
    add(6'b001000, 0, 1, 9, AIEX, 5);  add(6'b001000, 0, 1, 10, AIWB, 5);
    add(6'b000010, 0, 1, 0, F_RDY, 6); add(6'b000010, 0, 1, 1, DEC, 6);
    add(6'b000010, 0, 1, 11, JMP, 6);
    add(6'b111111, 0, 1, 0, F_RDY, 7); add(6'b111111, 0, 1, 1, DEC, 7);
    add(6'b000101, 0, 1, 0, F_RDY, 7); add(6'b000101, 0, 1, 1, DEC, 7);
`ifdef BNE_SUPPORT_EN
    add(6'b000101, 0, 1, 8, BR_T, 7);  add(6'b000000, 0, 0, 0, F_WAIT, 8);
`else
    add(6'b000000, 0, 0, 0, F_WAIT, 7);
`endif
    #1;
    check("reset.state", {28'd0, State}, 32'd0);
    check("reset.ctl", {17'd0, ctl_now()}, 32'd0);
    check("reset.count", InstrCount, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) drive(vecs[i], $sformatf("row%0d", i));
    run(6'b101011, 0, 1, 0, F_RDY, InstrCount, "sw_f");
    run(6'b101011, 0, 1, 1, DEC, InstrCount, "sw_d");
    run(6'b101011, 0, 1, 2, MADR, InstrCount, "sw_a");
    run(6'b101011, 0, 0, 5, MWR, InstrCount, "sw_w");
    #2 reset = 1'b0;
    #1;
    check("abort.state", {28'd0, State}, 32'd0);
    check("abort.ctl", {17'd0, ctl_now()}, {17'd0, C_ZERO});
    check("abort.count", InstrCount, 32'd0);
    @(negedge clk);
    check("held.ctl", {17'd0, ctl_now()}, {17'd0, C_ZERO});
    reset = 1'b1;
    run(6'b000000, 0, 0, 0, F_WAIT, 0, "rel0");
    run(6'b000000, 0, 0, 0, F_WAIT, 0, "rel1");
    run(6'b000000, 0, 1, 0, F_RDY, 0, "rel2");
    run(6'b000000, 0, 1, 1, DEC, 0, "rel3");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock
- reset  in  1  active-low reset; asserts asynchronously
- Opcode  in  6  instruction opcode from instruction register
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCEn  out  1  PC register load enable
- IorD  out  1  memory address select (0 PC, 1 ALUOut)
- MemRead, MemWrite, IRWrite, RegWrite  out  1 each  strobes
- RegDst, MemtoReg, ALUSrcA  out  1 each  mux selects
- ALUSrcB  out  2  ALU B-operand select (00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2)
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- State  out  4  current state encoding (debug)
- InstrCount  out  32  retired-instruction counter

Function
REQ-002 The FSM SHALL have states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next cycle.
REQ-003 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCEn SHALL be asserted only in the cycle MemReady=1; the FSM stays in FETCH while MemReady=0 and goes to DECODE when MemReady=1.
REQ-004 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state: 000000->EXEC, 100011/101011->MEMADR, 000100 (BEQ)->BRANCH, 000101 (BNE)->BRANCH per REQ-016, 001000->ADDIEX, 000010->JUMP, any other opcode->FETCH with no write strobes.
REQ-005 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; LW->MEMRD, SW->MEMWR.
REQ-006 MEMRD: MemRead=1, IorD=1; the FSM holds until MemReady=1, then goes to MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, then FETCH.
REQ-007 MEMWR: MemWrite=1, IorD=1; the FSM holds until MemReady=1, then goes to FETCH. MemWrite SHALL remain asserted throughout the hold.
REQ-008 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then ALUWB. ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, then FETCH.
REQ-009 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01; PCEn = (BEQ & Zero) | (BNE & ~Zero), evaluated combinationally in the same cycle, then FETCH.
REQ-010 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, then FETCH.
REQ-011 JUMP: PCSource=10, PCEn=1, then FETCH.
REQ-012 Any output not listed for a state SHALL be 0. Outputs SHALL be Moore-style from State, except the MemReady gating in REQ-003 and the Zero gating in REQ-009.
REQ-013 InstrCount SHALL increment by 1 on the clock edge leaving a terminal state (MEMWB, MEMWR with MemReady=1, ALUWB, BRANCH, ADDIWB, JUMP), SHALL wrap from 0xFFFFFFFF to 0, and SHALL NOT increment for illegal opcodes.

Reset
REQ-014 While reset=0, State SHALL be FETCH, InstrCount SHALL be 0, and every control output SHALL be forced to 0.
REQ-015 Reset assertion mid-access (for example in MEMWR) SHALL abort immediately. After release, the first rising edge SHALL evaluate FETCH.

Configuration
REQ-016 Macro BNE_SUPPORT_EN:
- When defined, opcode 000101 is decoded as BNE per REQ-004 and REQ-009.
- When undefined, 000101 is illegal and goes DECODE->FETCH with no strobes, no count, and the BNE term of PCEn is removed.

Structure
REQ-017 A shared package mips_ctrl_pkg SHALL hold the state encodings, opcode constants, and the ALUOp and PCSource constants.
REQ-018 The PCEn equation SHALL live in one sub-module, pc_enable_logic. Its inputs are the FETCH/JUMP unconditional enable, the BRANCH qualifier, Opcode, and Zero.

Verification
REQ-019 The bench SHALL cover the following scenarios:
- R-type: Opcode=000000, MemReady=1 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 in ALUWB. InstrCount 0->1.
- LW with MemReady low 3 cycles in MEMRD -> State=3 for 4 cycles, then 4. RegWrite=1 and MemtoReg=1 once.
- BEQ: Zero=1 -> PCEn=1 and PCSource=01 in BRANCH. Zero=0 -> PCEn=0. Both increment the count.
- BNE with Zero=0: PCEn=1 when BNE_SUPPORT_EN is defined. When undefined, DECODE->FETCH and InstrCount is unchanged.
- Illegal opcode 111111 -> states 0,1,0. No write strobes. Count unchanged.
- reset=0 asserted during MEMWR -> outputs go to 0 at once. After release: State=0, InstrCount=0, first MemRead=1.
